// File: rtl/waveform_sequencer.sv
// Playlist controller: steps through a table of {sel, DDS step, dwell} entries,
// driving the waveform generator select and the DDS phase increment.
// Latency: start sampled at edge T, entry 0 outputs at edge T+1.
// Flow control: none. start is ignored while busy, and stop aborts at the next edge.
// Optional feature: define WAVESEQ_LOOP_EN to honour the loop input.
// Without it, loop is ignored and every pass ends with done.
module waveform_sequencer #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int STEP_W  = 8,
   parameter int DWELL_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [AW-1:0]                 wr_addr,
   input  logic [3+STEP_W+DWELL_W-1:0]   wr_data,
   input  logic [AW:0]                   seq_len,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          loop,
   output logic [2:0]                    sel_out,
   output logic [STEP_W-1:0]             dds_step,
   output logic [AW-1:0]                 entry_idx,
   output logic                          busy,
   output logic                          done
);

   localparam int          DW      = 3 + STEP_W + DWELL_W;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

   // Table storage. It is deliberately left out of reset.
   logic [DW-1:0]        table_q [DEPTH];

   // Sequencer state
   state_t               state_q;
   logic [AW:0]          len_q;
   logic [AW-1:0]        idx_q;
   logic [DWELL_W-1:0]   cnt_q;

   // Registered outputs
   logic [2:0]           sel_q;
   logic [STEP_W-1:0]    step_q;
   logic [AW-1:0]        eidx_q;
   logic                 busy_q;
   logic                 done_q;

   // Combinational helpers
   logic [DW-1:0]        fetch_d;
   logic [2:0]           fetch_sel_d;
   logic [STEP_W-1:0]    fetch_step_d;
   logic [DWELL_W-1:0]   fetch_dwell_d;
   logic [DWELL_W-1:0]   load_cnt_d;
   logic [AW:0]          len_clamp_d;
   logic                 is_last_d;
   logic                 loop_en_d;

`ifdef WAVESEQ_LOOP_EN
   assign loop_en_d = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_en_d   = 1'b0;
`endif

   // The table is read before this edge's write lands.
   // A write to the entry being fetched therefore returns the old contents.
   assign fetch_d       = table_q[idx_q];
   assign fetch_sel_d   = fetch_d[2:0];
   assign fetch_step_d  = fetch_d[STEP_W+2:3];
   assign fetch_dwell_d = fetch_d[DW-1:STEP_W+3];

   // A dwell of zero still holds the entry for one RUN cycle.
   assign load_cnt_d    = (fetch_dwell_d == '0) ? DWELL_W'(1) : fetch_dwell_d;

   // Oversized lengths are clamped to the table depth.
   assign len_clamp_d   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;

   // The increment form avoids underflow of len_q - 1.
   assign is_last_d     = (({1'b0, idx_q} + (AW+1)'(1)) == len_q);

   // Table write port: synchronous and accepted in every state.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         table_q[wr_addr] <= wr_data;
      end
   end

   // Sequencer FSM with registered outputs.
   // Priority is rst, then stop while active, then the normal state flow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         step_q  <= '0;
         eidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (stop && (state_q != IDLE)) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         step_q  <= '0;
         eidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               // A stop arriving in the same cycle cancels the start.
               // A zero-length start is dropped silently.
               if (start && !stop && (seq_len != '0)) begin
                  len_q   <= len_clamp_d;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               sel_q   <= fetch_sel_d;
               step_q  <= fetch_step_d;
               eidx_q  <= idx_q;
               cnt_q   <= load_cnt_d;
               state_q <= RUN;
            end
            RUN: begin
               cnt_q <= cnt_q - DWELL_W'(1);
               if (cnt_q == DWELL_W'(1)) begin
                  if (!is_last_d) begin
                     idx_q   <= idx_q + AW'(1);
                     state_q <= LOAD;
                  end else if (loop_en_d) begin
                     idx_q   <= '0;
                     state_q <= LOAD;
                  end else begin
                     // The last entry stays visible during FIN, and done is raised.
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               idx_q   <= '0;
               sel_q   <= '0;
               step_q  <= '0;
               eidx_q  <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sel_out   = sel_q;
   assign dds_step  = step_q;
   assign entry_idx = eidx_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // done only occurs in FIN, where busy has already dropped.
   a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_q);

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer.
// A hold-count playlist model is compared against the DUT every cycle.
// Hand-computed traces pin the model.
module tb_waveform_sequencer;

   localparam int DW = 27;

`ifdef WAVESEQ_LOOP_EN
   localparam bit LOOP_ON = 1'b1;
`else
   localparam bit LOOP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, wr_en, start, stop, loop;
   logic [2:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    seq_len;
   logic [2:0]    sel_out;
   logic [7:0]    dds_step;
   logic [2:0]    entry_idx;
   logic          busy, done;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   waveform_sequencer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .seq_len(seq_len), .start(start), .stop(stop), .loop(loop),
      .sel_out(sel_out), .dds_step(dds_step), .entry_idx(entry_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int sel, input int step, input int dwell);
      logic [2:0]  s = 3'(sel);
      logic [7:0]  p = 8'(step);
      logic [15:0] d = 16'(dwell);
      return {d, p, s};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An entry is visible for max(dwell,1)+1 cycles once it appears.
   // In its final visible cycle, the model decides between the next entry,
   // a loop back to entry 0, or completion with done.
   logic [DW-1:0] m_tab [8];
   bit            m_on = 1'b0;
   bit            m_fetch;
   int            m_left, m_idx, m_len;
   logic [2:0]    e_sel = '0;
   logic [7:0]    e_step = '0;
   logic [2:0]    e_idx = '0;
   logic          e_busy = 1'b0, e_done = 1'b0;

   task automatic m_zero();
      m_on = 1'b0; e_sel = '0; e_step = '0; e_idx = '0; e_busy = 1'b0; e_done = 1'b0;
   endtask

   task automatic m_step();
      int d, l;
      if (rst) m_zero();
      else if (stop && m_on) m_zero();
      else if (!m_on) begin
         l = int'(seq_len);
         if (start && !stop && l != 0) begin
            m_on = 1'b1; m_len = (l > 8) ? 8 : l; m_idx = 0;
            m_left = 1; m_fetch = 1'b1; e_busy = 1'b1;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (m_fetch) begin
               d = int'(m_tab[m_idx][26:11]);
               e_sel = m_tab[m_idx][2:0]; e_step = m_tab[m_idx][10:3]; e_idx = 3'(m_idx);
               m_left = ((d == 0) ? 1 : d) + 1;
            end else m_zero();
         end else if (m_left == 1) begin
            if (m_idx < m_len - 1) begin m_idx++; m_fetch = 1'b1; end
            else if (LOOP_ON && loop) begin m_idx = 0; m_fetch = 1'b1; end
            else begin m_fetch = 1'b0; e_busy = 1'b0; e_done = 1'b1; end
         end
      end
      if (wr_en) m_tab[wr_addr] = wr_data;
   endtask

   initial forever begin
      @(posedge clk);
      m_step();
   end

   // Per-cycle comparison of the DUT against the model, taken away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en)
         chk("cycle", {19'd0, sel_out, dds_step, entry_idx, busy, done},
                      {19'd0, e_sel, e_step, e_idx, e_busy, e_done});
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; tick(); wr_en = 1'b0;
   endtask

   task automatic go(input int len);
      seq_len = 4'(len); start = 1'b1; tick(); start = 1'b0;
   endtask

   logic [2:0] a_sel  [9] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd0};
   logic       a_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       a_done [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0] b_sel  [4] = '{3'd0, 3'd5, 3'd5, 3'd0};
   logic       b_busy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic       b_done [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int dn;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; seq_len = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      tick(); chk_en = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {24'd0, sel_out, dds_step, busy, done}, 32'd0);
      chk("reset_idx", {29'd0, entry_idx}, 32'd0);
      tick();
      for (int i = 0; i < 8; i++) wr(i, mk(i, 16 * i + 1, i % 3));

      // Two-entry pass: hand-computed trace
      wr(0, mk(1, 4, 3)); wr(1, mk(3, 16, 2));
      go(2);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("pinA_sel", {29'd0, sel_out}, {29'd0, a_sel[k]});
         chk("pinA_busy", {31'd0, busy}, {31'd0, a_busy[k]});
         chk("pinA_done", {31'd0, done}, {31'd0, a_done[k]});
      end
      tick();

      // Dwell of zero holds for two cycles
      wr(2, mk(1, 4, 3));
      wr(0, mk(5, 7, 0));
      go(1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("pinB_sel", {29'd0, sel_out}, {29'd0, b_sel[k]});
         chk("pinB_busy", {31'd0, busy}, {31'd0, b_busy[k]});
         chk("pinB_done", {31'd0, done}, {31'd0, b_done[k]});
      end
      tick();

      // A zero-length start is ignored
      go(0);
      tick(); tick();
      chk("len0_busy", {31'd0, busy}, 32'd0);

      // Stop in the second RUN cycle of e1
      wr(0, mk(1, 4, 3));
      go(2);
      for (int i = 0; i < 6; i++) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      @(negedge clk);
      chk("stop_outputs", {19'd0, sel_out, dds_step, entry_idx, busy, done}, 32'd0);
      tick(); tick();

      // start and stop together from IDLE
      seq_len = 4'd2; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("startstop_busy", {31'd0, busy}, 32'd0);
      tick();

      // A write during e0 is used; a write at e1's LOAD edge is not. A start while busy is ignored.
      go(2);
      tick();
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = mk(6, 8'hA5, 2); tick();
      wr_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
      tick();
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = mk(2, 8'h3C, 1); tick(); wr_en = 1'b0;
      @(negedge clk);
      chk("wr_old_step", {24'd0, dds_step}, 32'h0000_00A5);
      chk("wr_old_sel", {29'd0, sel_out}, 32'd6);
      for (int i = 0; i < 8; i++) tick();

      // Loop behaviour, which depends on the build
      wr(1, mk(3, 16, 2));
      loop = 1'b1;
      go(2);
      dn = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); dn += int'(done); end
      chk("loop_done_count", 32'(dn), LOOP_ON ? 32'd0 : 32'd1);
      loop = 1'b0;
      dn = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); dn += int'(done); end
      chk("loop_release_done", 32'(dn), LOOP_ON ? 32'd1 : 32'd0);
      tick();

      // Randomized stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 599) == 0);
         start   = ($urandom_range(0, 5) == 0);
         stop    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) loop = ~loop;
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = mk($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 4));
         seq_len = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; loop = 1'b0;
      for (int i = 0; i < 60; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
